// File: rtl/rim_path_checker_if.sv
// -----------------------------------------------------------------------------
// rim_path_checker_if
// Bundles the maze-load snoop, the solver's path stream and the checker's
// verdict outputs into one interface.
//
// Signals:
//   in_valid   maze byte strobe (shared with the solver)
//   maze[7:0]  maze row, bit c = column c, 1 = open
//   path_valid solver out_valid
//   path_row   solver out_row
//   path_col   solver out_col
//   done       one-cycle verdict pulse
//   pass       verdict, 1 = legal path
//   err_code   first error detected
//   path_len   beats received, saturating at 31
//
// Modports:
//   master  drives the load and path stream, observes the verdict
//   slave   the checker itself
// -----------------------------------------------------------------------------
interface rim_path_checker_if;
    logic       in_valid;
    logic [7:0] maze;
    logic       path_valid;
    logic [2:0] path_row;
    logic [2:0] path_col;
    logic       done;
    logic       pass;
    logic [2:0] err_code;
    logic [4:0] path_len;

    modport master (
        output in_valid, maze, path_valid, path_row, path_col,
        input  done, pass, err_code, path_len
    );

    modport slave (
        input  in_valid, maze, path_valid, path_row, path_col,
        output done, pass, err_code, path_len
    );
endinterface

// File: rtl/rim_path_checker.sv
// -----------------------------------------------------------------------------
// rim_path_checker
// Receiving end of the rat-in-maze solver. Snoops the 8-byte maze load,
// captures the solver's coordinate stream and checks that it is a legal
// monotonic path: starts at (0,0), one step down or right per beat, only
// open cells, exactly PATH_LEN beats. Produces a latched verdict.
//
// Parameters:
//   TIMEOUT   idle cycles allowed after the load before the first beat
//   PATH_LEN  required number of path beats
//
// Ports:
//   clk   system clock, rising edge
//   rst   asynchronous active-high reset
//   bus   rim_path_checker_if.slave (load snoop, path stream, verdict)
//
// Error codes: 0 none, 1 bad start, 2 bad step, 3 blocked, 4 too short,
//              5 too long, 6 timeout, 7 short load.
// -----------------------------------------------------------------------------
module rim_path_checker #(
    parameter int TIMEOUT  = 255,
    parameter int PATH_LEN = 15
) (
    input  logic              clk,
    input  logic              rst,
    rim_path_checker_if.slave bus
);

    localparam int              TW           = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]   TIMEOUT_LAST = TW'(TIMEOUT - 1);
    localparam logic [4:0]      LEN_REQ      = 5'(PATH_LEN);
    localparam logic [4:0]      LEN_OVER     = 5'(PATH_LEN + 1);
    localparam logic [4:0]      LEN_MAX      = 5'd31;

    localparam logic [2:0] E_NONE      = 3'd0;
    localparam logic [2:0] E_BAD_START = 3'd1;
    localparam logic [2:0] E_BAD_STEP  = 3'd2;
    localparam logic [2:0] E_BLOCKED   = 3'd3;
    localparam logic [2:0] E_SHORT     = 3'd4;
    localparam logic [2:0] E_LONG      = 3'd5;
    localparam logic [2:0] E_TIMEOUT   = 3'd6;
    localparam logic [2:0] E_SHORT_LD  = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WAIT,
        ST_CHECK,
        ST_REPORT
    } state_t;

    // ---------------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------------
    state_t        state_q, state_d;
    logic [2:0]    row_idx_q, row_idx_d;
    logic [TW-1:0] tcount_q, tcount_d;
    logic [4:0]    cnt_q, cnt_d;
    logic [2:0]    prev_row_q, prev_row_d;
    logic [2:0]    prev_col_q, prev_col_d;
    logic [2:0]    err_q, err_d;
    logic          pass_q, pass_d;
    logic [4:0]    len_q, len_d;
    logic          done_q, done_d;

    logic [7:0]    maze_mem [8];
    logic          mem_we;
    logic [2:0]    mem_addr;

    // ---------------------------------------------------------------------
    // Per-beat evaluation of the incoming coordinate
    // ---------------------------------------------------------------------
    logic       first_beat;
    logic       at_origin;
    logic       step_ok;
    logic       cell_open;
    logic [4:0] cnt_inc;
    logic [2:0] beat_code;

    // Step arithmetic is deliberately 3 bits wide: a step off the bottom or
    // right edge wraps to row/column 0 and is accepted as a step, so an
    // overlong stream that keeps going is reported as too long rather than
    // as a bad step.
    always_comb begin
        first_beat = (state_q == ST_WAIT);
        at_origin  = (bus.path_row == 3'd0) && (bus.path_col == 3'd0);
        step_ok    = ((bus.path_row == prev_row_q + 3'd1) && (bus.path_col == prev_col_q)) ||
                     ((bus.path_row == prev_row_q) && (bus.path_col == prev_col_q + 3'd1));
        cell_open  = maze_mem[bus.path_row][bus.path_col];

        if (first_beat) begin
            cnt_inc = 5'd1;
        end else if (cnt_q == LEN_MAX) begin
            cnt_inc = LEN_MAX;
        end else begin
            cnt_inc = cnt_q + 5'd1;
        end

        beat_code = E_NONE;
        if (first_beat && !at_origin) begin
            beat_code = E_BAD_START;
        end else if (!first_beat && !step_ok) begin
            beat_code = E_BAD_STEP;
        end else if (!cell_open) begin
            beat_code = E_BLOCKED;
        end else if (cnt_inc == LEN_OVER) begin
            beat_code = E_LONG;
        end
    end

    // ---------------------------------------------------------------------
    // Next-state and datapath control
    // ---------------------------------------------------------------------
    logic load_start;
    logic [2:0] final_err;

    always_comb begin
        state_d    = state_q;
        row_idx_d  = row_idx_q;
        tcount_d   = tcount_q;
        cnt_d      = cnt_q;
        prev_row_d = prev_row_q;
        prev_col_d = prev_col_q;
        err_d      = err_q;
        pass_d     = pass_q;
        len_d      = len_q;
        done_d     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = row_idx_q;
        final_err  = err_q;

        // Outside LOAD, a maze byte always begins a fresh load as row 0.
        // This covers a new load from IDLE/REPORT, aborting a check in
        // WAIT/CHECK, and the 9th byte of an overlong burst (seen in WAIT).
        load_start = bus.in_valid && (state_q != ST_LOAD);

        if (load_start) begin
            mem_we    = 1'b1;
            mem_addr  = 3'd0;
            row_idx_d = 3'd1;
            cnt_d     = 5'd0;
            err_d     = E_NONE;
            pass_d    = 1'b0;
            len_d     = 5'd0;
            state_d   = ST_LOAD;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_REPORT: begin
                end

                ST_LOAD: begin
                    if (bus.in_valid) begin
                        mem_we    = 1'b1;
                        mem_addr  = row_idx_q;
                        row_idx_d = row_idx_q + 3'd1;
                        if (row_idx_q == 3'd7) begin
                            tcount_d = '0;
                            state_d  = ST_WAIT;
                        end
                    end else begin
                        err_d   = E_SHORT_LD;
                        pass_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = ST_REPORT;
                    end
                end

                ST_WAIT, ST_CHECK: begin
                    if (bus.path_valid) begin
                        cnt_d      = cnt_inc;
                        prev_row_d = bus.path_row;
                        prev_col_d = bus.path_col;
                        if (err_q == E_NONE) begin
                            err_d = beat_code;
                        end
                        state_d = ST_CHECK;
                    end else if (state_q == ST_WAIT) begin
                        tcount_d = tcount_q + 1'b1;
                        if (tcount_q == TIMEOUT_LAST) begin
                            err_d   = E_TIMEOUT;
                            pass_d  = 1'b0;
                            done_d  = 1'b1;
                            state_d = ST_REPORT;
                        end
                    end else begin
                        // Stream ended: the previous edge held the last beat.
                        if ((err_q == E_NONE) && (cnt_q < LEN_REQ)) begin
                            final_err = E_SHORT;
                        end
                        err_d   = final_err;
                        pass_d  = (final_err == E_NONE);
                        len_d   = cnt_q;
                        done_d  = 1'b1;
                        state_d = ST_REPORT;
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // State and control registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            row_idx_q  <= 3'd0;
            tcount_q   <= '0;
            cnt_q      <= 5'd0;
            prev_row_q <= 3'd0;
            prev_col_q <= 3'd0;
            err_q      <= E_NONE;
            pass_q     <= 1'b0;
            len_q      <= 5'd0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            row_idx_q  <= row_idx_d;
            tcount_q   <= tcount_d;
            cnt_q      <= cnt_d;
            prev_row_q <= prev_row_d;
            prev_col_q <= prev_col_d;
            err_q      <= err_d;
            pass_q     <= pass_d;
            len_q      <= len_d;
            done_q     <= done_d;
        end
    end

    // ---------------------------------------------------------------------
    // Maze store: one byte per row, written during the load
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                maze_mem[i] <= 8'h00;
            end
        end else if (mem_we) begin
            maze_mem[mem_addr] <= bus.maze;
        end
    end

    assign bus.done     = done_q;
    assign bus.pass     = pass_q;
    assign bus.err_code = err_q;
    assign bus.path_len = len_q;

endmodule
